// File: rtl/instruction_cache_pkg.sv
// Shared sizing and FSM encodings for the direct-mapped instruction cache.
package instruction_cache_pkg;

  localparam int IC_DAT_W     = 32;
  localparam int ICACHE_IDX_W = 6;
  localparam int ICACHE_TAG_W = IC_DAT_W - ICACHE_IDX_W - 2;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and controller-side handshake bundle of the instruction cache.
interface instruction_cache_if import instruction_cache_pkg::*; #(
  parameter int DAT_W = IC_DAT_W
) ();

  logic             en;
  logic             br_flag;
  logic             if_en_i;
  logic [DAT_W-1:0] if_pc_i;
  logic             if_en_o;
  logic [DAT_W-1:0] if_ins_o;
  logic             mc_en_o;
  logic [DAT_W-1:0] mc_pc_o;
  logic             mc_en_i;
  logic [DAT_W-1:0] mc_ins_i;

  modport slave (
    input  en, br_flag, if_en_i, if_pc_i, mc_en_i, mc_ins_i,
    output if_en_o, if_ins_o, mc_en_o, mc_pc_o
  );

  modport master (
    output en, br_flag, if_en_i, if_pc_i, mc_en_i, mc_ins_i,
    input  if_en_o, if_ins_o, mc_en_o, mc_pc_o
  );

endinterface

// File: rtl/icache_store.sv
// Valid/tag/data arrays: combinational read port, synchronous write port,
// valid bits cleared only by reset.
module icache_store import instruction_cache_pkg::*; #(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = ICACHE_TAG_W,
  parameter int DAT_W = IC_DAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [DAT_W-1:0] rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [DAT_W-1:0] wr_data_i
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [DAT_W-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache: one-cycle hits,
// single-pulse word fetch on a miss, branch flush abandons the miss.
module instruction_cache import instruction_cache_pkg::*; #(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int DAT_W = IC_DAT_W
) (
  input  logic                clk,
  input  logic                rst,
  instruction_cache_if.slave  bus
);

  localparam int TAG_W = DAT_W - IDX_W - 2;

  ic_state_e        state_q;
  logic [DAT_W-1:0] req_pc_q;
  logic [DAT_W-1:0] if_ins_q;
  logic             if_en_q;
  logic             mc_en_q;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [DAT_W-1:0] rd_data;
  logic             hit;
  logic             fill_we;
  logic             unused_pc_lo;

  assign unused_pc_lo = ^bus.if_pc_i[1:0];

  icache_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DAT_W (DAT_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bus.if_pc_i[IDX_W+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we),
    .wr_idx_i   (req_pc_q[IDX_W+1:2]),
    .wr_tag_i   (req_pc_q[DAT_W-1:IDX_W+2]),
    .wr_data_i  (bus.mc_ins_i)
  );

  assign hit = rd_valid && (rd_tag == bus.if_pc_i[DAT_W-1:IDX_W+2]);

  // The returned word is correct for req_pc even when a flush lands on the
  // same cycle, so the fill ignores br_flag.
  assign fill_we = bus.en && (state_q == IC_MISS) && bus.mc_en_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IC_IDLE;
      req_pc_q <= '0;
      if_ins_q <= '0;
      if_en_q  <= 1'b0;
      mc_en_q  <= 1'b0;
    end else if (bus.en) begin
      if_en_q <= 1'b0;
      mc_en_q <= 1'b0;
      if (bus.br_flag) begin
        state_q <= IC_IDLE;
      end else begin
        case (state_q)
          IC_IDLE: begin
            if (bus.if_en_i) begin
              if (hit) begin
                if_en_q  <= 1'b1;
                if_ins_q <= rd_data;
              end else begin
                req_pc_q <= {bus.if_pc_i[DAT_W-1:2], 2'b00};
                mc_en_q  <= 1'b1;
                state_q  <= IC_MISS;
              end
            end
          end
          IC_MISS: begin
            if (bus.mc_en_i) begin
              if_en_q  <= 1'b1;
              if_ins_q <= bus.mc_ins_i;
              state_q  <= IC_IDLE;
            end
          end
          default: state_q <= IC_IDLE;
        endcase
      end
    end
  end

  assign bus.if_en_o  = if_en_q;
  assign bus.if_ins_o = if_ins_q;
  assign bus.mc_en_o  = mc_en_q;
  assign bus.mc_pc_o  = req_pc_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed scenario bench for instruction_cache.
module tb_instruction_cache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mc_cnt = 0;
  int   if_cnt = 0;

  always #5 clk = ~clk;

  instruction_cache_if #(.DAT_W(32)) bus ();

  instruction_cache #(.IDX_W(6), .DAT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.mc_en_o === 1'b1) mc_cnt++;
    if (bus.if_en_o === 1'b1) if_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc);
    bus.if_en_i = 1'b1;
    bus.if_pc_i = pc;
    step();
    bus.if_en_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] word);
    bus.mc_ins_i = word;
    bus.mc_en_i  = 1'b1;
    step();
    bus.mc_en_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.if_en_o !== 1'b0) begin errors++; $display("FAIL reset_if_en got=%b exp=0", bus.if_en_o); end
    checks++; if (bus.if_ins_o !== 32'h0) begin errors++; $display("FAIL reset_if_ins got=%h exp=0", bus.if_ins_o); end
    checks++; if (bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL reset_mc_en got=%b exp=0", bus.mc_en_o); end
    checks++; if (bus.mc_pc_o !== 32'h0) begin errors++; $display("FAIL reset_mc_pc got=%h exp=0", bus.mc_pc_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    issue(32'h0000_1003);
    checks++; if (bus.mc_en_o !== 1'b1) begin errors++; $display("FAIL cold_mc_en got=%b exp=1", bus.mc_en_o); end
    checks++; if (bus.mc_pc_o !== 32'h0000_1000) begin errors++; $display("FAIL cold_mc_pc got=%h exp=00001000", bus.mc_pc_o); end
    checks++; if (bus.if_en_o !== 1'b0) begin errors++; $display("FAIL cold_if_en_early got=%b exp=0", bus.if_en_o); end
    step();
    checks++; if (bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL cold_mc_pulse got=%b exp=0", bus.mc_en_o); end
    step();
    step();
    respond(32'h0010_0093);
    checks++; if (bus.if_en_o !== 1'b1) begin errors++; $display("FAIL cold_if_en got=%b exp=1", bus.if_en_o); end
    checks++; if (bus.if_ins_o !== 32'h0010_0093) begin errors++; $display("FAIL cold_if_ins got=%h exp=00100093", bus.if_ins_o); end
    step();
    checks++; if (bus.if_en_o !== 1'b0) begin errors++; $display("FAIL cold_if_pulse got=%b exp=0", bus.if_en_o); end
    issue(32'h0000_1000);
    checks++; if (bus.if_en_o !== 1'b1) begin errors++; $display("FAIL refetch_hit_en got=%b exp=1", bus.if_en_o); end
    checks++; if (bus.if_ins_o !== 32'h0010_0093) begin errors++; $display("FAIL refetch_hit_ins got=%h exp=00100093", bus.if_ins_o); end
    checks++; if (bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL refetch_no_mc got=%b exp=0", bus.mc_en_o); end
    step();
  endtask

  task automatic test_conflict();
    issue(32'h0000_1100);
    checks++; if (bus.mc_en_o !== 1'b1) begin errors++; $display("FAIL conflict_miss got=%b exp=1", bus.mc_en_o); end
    checks++; if (bus.mc_pc_o !== 32'h0000_1100) begin errors++; $display("FAIL conflict_mc_pc got=%h exp=00001100", bus.mc_pc_o); end
    step();
    respond(32'hAAAA_0001);
    checks++; if (bus.if_ins_o !== 32'hAAAA_0001 || bus.if_en_o !== 1'b1) begin errors++; $display("FAIL conflict_fill got=%b/%h exp=1/aaaa0001", bus.if_en_o, bus.if_ins_o); end
    step();
    issue(32'h0000_1000);
    checks++; if (bus.mc_en_o !== 1'b1 || bus.if_en_o !== 1'b0) begin errors++; $display("FAIL conflict_evicted got=mc%b/if%b exp=mc1/if0", bus.mc_en_o, bus.if_en_o); end
    step();
    respond(32'h0010_0093);
    checks++; if (bus.if_ins_o !== 32'h0010_0093) begin errors++; $display("FAIL conflict_refill got=%h exp=00100093", bus.if_ins_o); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0008);
    step();
    respond(32'h0000_0080);
    step();
    issue(32'h0000_000C);
    step();
    respond(32'h0000_00C0);
    step();
    bus.if_en_i = 1'b1;
    bus.if_pc_i = 32'h0000_0008;
    step();
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0000_0080) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/00000080", bus.if_en_o, bus.if_ins_o); end
    bus.if_pc_i = 32'h0000_000C;
    step();
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0000_00C0) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/000000c0", bus.if_en_o, bus.if_ins_o); end
    bus.if_pc_i = 32'h0000_0008;
    step();
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0000_0080) begin errors++; $display("FAIL b2b_third got=%b/%h exp=1/00000080", bus.if_en_o, bus.if_ins_o); end
    bus.if_en_i = 1'b0;
    step();
    checks++; if (bus.if_en_o !== 1'b0 || bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL b2b_quiet got=if%b/mc%b exp=if0/mc0", bus.if_en_o, bus.mc_en_o); end
  endtask

  task automatic test_flush();
    int if0;
    issue(32'h0000_2000);
    checks++; if (bus.mc_en_o !== 1'b1 || bus.mc_pc_o !== 32'h0000_2000) begin errors++; $display("FAIL flush_req got=%b/%h exp=1/00002000", bus.mc_en_o, bus.mc_pc_o); end
    if0 = if_cnt;
    step();
    step();
    bus.br_flag = 1'b1;
    bus.if_en_i = 1'b1;
    bus.if_pc_i = 32'h0000_2800;
    step();
    bus.br_flag = 1'b0;
    bus.if_en_i = 1'b0;
    checks++; if (bus.if_en_o !== 1'b0 || bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL flush_outputs got=if%b/mc%b exp=if0/mc0", bus.if_en_o, bus.mc_en_o); end
    step();
    checks++; if (if_cnt != if0) begin errors++; $display("FAIL flush_no_if_en got=%0d exp=%0d", if_cnt, if0); end
    issue(32'h0000_3000);
    checks++; if (bus.mc_en_o !== 1'b1 || bus.mc_pc_o !== 32'h0000_3000) begin errors++; $display("FAIL flush_new_req got=%b/%h exp=1/00003000", bus.mc_en_o, bus.mc_pc_o); end
    step();
    respond(32'h0030_0013);
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0030_0013) begin errors++; $display("FAIL flush_new_rsp got=%b/%h exp=1/00300013", bus.if_en_o, bus.if_ins_o); end
    step();
  endtask

  task automatic test_br_fill();
    issue(32'h0000_4000);
    step();
    bus.mc_ins_i = 32'h0040_0013;
    bus.mc_en_i  = 1'b1;
    bus.br_flag  = 1'b1;
    step();
    bus.mc_en_i  = 1'b0;
    bus.br_flag  = 1'b0;
    checks++; if (bus.if_en_o !== 1'b0) begin errors++; $display("FAIL brfill_no_if_en got=%b exp=0", bus.if_en_o); end
    step();
    checks++; if (bus.if_en_o !== 1'b0) begin errors++; $display("FAIL brfill_no_late got=%b exp=0", bus.if_en_o); end
    issue(32'h0000_4000);
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0040_0013 || bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL brfill_hit got=if%b/%h/mc%b exp=if1/00400013/mc0", bus.if_en_o, bus.if_ins_o, bus.mc_en_o); end
    step();
  endtask

  task automatic test_en_stall();
    int c0;
    c0 = mc_cnt;
    issue(32'h0000_5000);
    checks++; if (bus.mc_en_o !== 1'b1) begin errors++; $display("FAIL stall_req got=%b exp=1", bus.mc_en_o); end
    step();
    bus.en       = 1'b0;
    bus.mc_ins_i = 32'h0050_0013;
    bus.mc_en_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.if_en_o !== 1'b0 || bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL stall_frozen%0d got=if%b/mc%b exp=if0/mc0", i, bus.if_en_o, bus.mc_en_o); end
    end
    bus.en = 1'b1;
    step();
    bus.mc_en_i = 1'b0;
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0050_0013) begin errors++; $display("FAIL stall_rsp got=%b/%h exp=1/00500013", bus.if_en_o, bus.if_ins_o); end
    step();
    checks++; if (mc_cnt - c0 != 1) begin errors++; $display("FAIL stall_mc_count got=%0d exp=1", mc_cnt - c0); end
  endtask

  task automatic test_rst_flush();
    issue(32'h0000_1000);
    checks++; if (bus.mc_en_o !== 1'b1) begin errors++; $display("FAIL rst_prefill_miss got=%b exp=1", bus.mc_en_o); end
    step();
    respond(32'h0010_0093);
    step();
    issue(32'h0000_1000);
    checks++; if (bus.if_en_o !== 1'b1 || bus.mc_en_o !== 1'b0) begin errors++; $display("FAIL rst_prefill_hit got=if%b/mc%b exp=if1/mc0", bus.if_en_o, bus.mc_en_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.if_en_o !== 1'b0 || bus.if_ins_o !== 32'h0 || bus.mc_pc_o !== 32'h0) begin errors++; $display("FAIL rst_outputs got=%b/%h/%h exp=0/0/0", bus.if_en_o, bus.if_ins_o, bus.mc_pc_o); end
    issue(32'h0000_1000);
    checks++; if (bus.mc_en_o !== 1'b1 || bus.if_en_o !== 1'b0) begin errors++; $display("FAIL rst_invalidated got=mc%b/if%b exp=mc1/if0", bus.mc_en_o, bus.if_en_o); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(32'h0000_1000);
    checks++; if (bus.mc_en_o !== 1'b1 || bus.mc_pc_o !== 32'h0000_1000) begin errors++; $display("FAIL rst_mid_miss_idle got=%b/%h exp=1/00001000", bus.mc_en_o, bus.mc_pc_o); end
    step();
    respond(32'h0010_0093);
    checks++; if (bus.if_en_o !== 1'b1 || bus.if_ins_o !== 32'h0010_0093) begin errors++; $display("FAIL rst_refill got=%b/%h exp=1/00100093", bus.if_en_o, bus.if_ins_o); end
    step();
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.br_flag  = 1'b0;
    bus.if_en_i  = 1'b0;
    bus.if_pc_i  = '0;
    bus.mc_en_i  = 1'b0;
    bus.mc_ins_i = '0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_br_fill();
    test_en_stall();
    test_rst_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
